// File: rtl/c43_timer_ctrl_if.sv
// CPU-side view of one c43 timer chain: preset/command strobes in,
// count value, carry and status back out.
interface c43_timer_ctrl_if;
  logic        WR_PRE;
  logic [11:0] PRE;
  logic        START;
  logic        STOP;
  logic        MODE;
  logic        CE;
  logic        IRQ_ACK;
  logic [11:0] Q;
  logic        CO;
  logic        TC;
  logic        BUSY;
  logic        DONE;
  logic        IRQ;

  modport master (
    output WR_PRE, PRE, START, STOP, MODE, CE, IRQ_ACK,
    input  Q, CO, TC, BUSY, DONE, IRQ
  );

  modport slave (
    input  WR_PRE, PRE, START, STOP, MODE, CE, IRQ_ACK,
    output Q, CO, TC, BUSY, DONE, IRQ
  );
endinterface

// File: rtl/c43_timer_ctrl.sv
// 12-bit interval timer: three 4-bit up-counter stages with look-ahead
// carry, sequenced by a small IDLE/RUN/DONE controller.
//
// state  | meaning
// S_IDLE | stopped, Q holds, waiting for START
// S_RUN  | counting on CE; terminal count reloads (MODE=1) or finishes
// S_DONE | one-shot reached FFF, Q holds FFF until START or STOP
module c43_timer_ctrl (
  input  logic              CK,
  input  logic              nRES,
  c43_timer_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_q;
  logic [11:0] r_preg;
  logic        r_tc;
  logic        r_irq;
  logic [11:0] w_q_nxt;
  logic [11:0] w_q_inc;
  logic [11:0] w_preset;
  logic        w_c1;
  logic        w_c2;
  logic        w_allf;
  logic        w_run;
  logic        w_term;

  // A preset written in the same cycle as START/reload takes effect at once.
  assign w_preset = bus.WR_PRE ? bus.PRE : r_preg;

  // Look-ahead carries: each stage sees CE ANDed with all-ones of every lower stage.
  always_comb begin
    w_c1    = bus.CE & (r_q[3:0] == 4'hF);
    w_c2    = w_c1 & (r_q[7:4] == 4'hF);
    w_q_inc = {r_q[11:8] + {3'b000, w_c2},
               r_q[7:4]  + {3'b000, w_c1},
               r_q[3:0]  + {3'b000, bus.CE}};
  end

  assign w_allf = &r_q;
  assign w_run  = (r_state == S_RUN);

  // Next state, next count and terminal-event decode; STOP overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_term      = 1'b0;
    if (bus.STOP) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.START) begin
            w_q_nxt     = w_preset;
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (bus.START) begin
            w_q_nxt = w_preset;
          end else if (bus.CE) begin
            if (w_allf) begin
              w_term = 1'b1;
              if (bus.MODE) begin
                w_q_nxt = w_preset;
              end else begin
                w_state_nxt = S_DONE;
              end
            end else begin
              w_q_nxt = w_q_inc;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, counter, preset, TC pulse and sticky IRQ registers.
  always_ff @(posedge CK) begin
    if (!nRES) begin
      r_state <= S_IDLE;
      r_q     <= 12'h000;
      r_preg  <= 12'h000;
      r_tc    <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_tc    <= w_term;
      r_irq   <= w_term | (r_irq & ~bus.IRQ_ACK);
      if (bus.WR_PRE) begin
        r_preg <= bus.PRE;
      end
    end
  end

  assign bus.Q    = r_q;
  assign bus.CO   = w_allf & bus.CE & w_run;
  assign bus.TC   = r_tc;
  assign bus.BUSY = (r_state == S_RUN);
  assign bus.DONE = (r_state == S_DONE);
  assign bus.IRQ  = r_irq;

endmodule

// File: tb/tb_c43_timer_ctrl.sv
// Directed bench for c43_timer_ctrl: a vector table for the short
// sequences plus hand-written loops for the long counting cases.
module tb_c43_timer_ctrl;

  logic CK = 1'b0;
  logic nRES;

  c43_timer_ctrl_if u_if ();

  c43_timer_ctrl u_dut (
    .CK   (CK),
    .nRES (nRES),
    .bus  (u_if.slave)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic        nres;
    logic        wr;
    logic [11:0] pre;
    logic        start;
    logic        stop;
    logic        mode;
    logic        ce;
    logic        ack;
    logic        co;
    logic [11:0] q;
    logic        tc;
    logic        busy;
    logic        done;
    logic        irq;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(
    input logic nres, input logic wr, input logic [11:0] pre,
    input logic start, input logic stop, input logic mode,
    input logic ce, input logic ack,
    input logic co, input logic [11:0] q, input logic tc,
    input logic busy, input logic done, input logic irq);
    vec_t v;
    v.nres = nres; v.wr = wr; v.pre = pre; v.start = start; v.stop = stop;
    v.mode = mode; v.ce = ce; v.ack = ack; v.co = co; v.q = q; v.tc = tc;
    v.busy = busy; v.done = done; v.irq = irq;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic nres, input logic wr, input logic [11:0] pre,
                       input logic start, input logic stop, input logic mode,
                       input logic ce, input logic ack);
    nRES = nres; u_if.WR_PRE = wr; u_if.PRE = pre; u_if.START = start;
    u_if.STOP = stop; u_if.MODE = mode; u_if.CE = ce; u_if.IRQ_ACK = ack;
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic apply(input int idx, input vec_t v);
    drive(v.nres, v.wr, v.pre, v.start, v.stop, v.mode, v.ce, v.ack);
    #2;
    chk($sformatf("v%0d co", idx), {15'd0, u_if.CO}, {15'd0, v.co});
    tick();
    chk($sformatf("v%0d q", idx), {4'd0, u_if.Q}, {4'd0, v.q});
    chk($sformatf("v%0d tc", idx), {15'd0, u_if.TC}, {15'd0, v.tc});
    chk($sformatf("v%0d busy", idx), {15'd0, u_if.BUSY}, {15'd0, v.busy});
    chk($sformatf("v%0d done", idx), {15'd0, u_if.DONE}, {15'd0, v.done});
    chk($sformatf("v%0d irq", idx), {15'd0, u_if.IRQ}, {15'd0, v.irq});
  endtask

  initial begin
    int          tc_seen;
    int          n;
    int          nce;
    int          tc_at;
    logic        cefl;
    logic        done_m;
    logic [11:0] exp_q;

    //                 nres wr pre     st sp md ce ak | co q       tc bz dn irq
    // reset mid-count at 123, with a preset write that reset must swallow
    tbl.push_back(mk(1, 1, 12'h120, 1, 0, 0, 0, 0,   0, 12'h120, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 0, 1, 0,   0, 12'h121, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 0, 1, 0,   0, 12'h122, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 0, 1, 0,   0, 12'h123, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 12'hFFF, 1, 0, 0, 1, 0,   0, 12'h000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 1, 0, 0, 0, 0,   0, 12'h000, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 0, 1, 0, 0, 0,   0, 12'h000, 0, 0, 0, 0));
    // auto-reload from FFA, CE continuous: TC every 6 edges
    tbl.push_back(mk(1, 1, 12'hFFA, 1, 0, 1, 1, 0,   0, 12'hFFA, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 1, 1, 0,   0, 12'hFFB, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 1, 1, 0,   0, 12'hFFC, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 1, 1, 0,   0, 12'hFFD, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 1, 1, 0,   0, 12'hFFE, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 1, 1, 0,   0, 12'hFFF, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 1, 1, 0,   1, 12'hFFA, 1, 1, 0, 1));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 1, 1, 0,   0, 12'hFFB, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 1, 1, 1,   0, 12'hFFC, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 1, 1, 0,   0, 12'hFFD, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 1, 1, 0,   0, 12'hFFE, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 1, 1, 0,   0, 12'hFFF, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 1, 1, 1,   1, 12'hFFA, 1, 1, 0, 1));
    // STOP freezes the count; IRQ survives until acked
    tbl.push_back(mk(1, 0, 12'h000, 0, 1, 1, 1, 0,   0, 12'hFFA, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 0, 0, 1,   0, 12'hFFA, 0, 0, 0, 0));
    // STOP colliding with a terminal event, then STOP+START
    tbl.push_back(mk(1, 1, 12'hFFE, 1, 0, 1, 0, 0,   0, 12'hFFE, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 1, 1, 0,   0, 12'hFFF, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 0, 1, 1, 1, 0,   1, 12'hFFF, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 1, 1, 0, 0, 0,   0, 12'hFFF, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 1, 0, 0, 0, 0,   0, 12'hFFE, 0, 1, 0, 0));
    // restart while terminal would occur, then one-shot finish
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 0, 1, 0,   0, 12'hFFF, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 1, 0, 0, 1, 0,   1, 12'hFFE, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 0, 1, 0,   0, 12'hFFF, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 0, 1, 0,   1, 12'hFFF, 1, 0, 1, 1));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 0, 1, 0,   0, 12'hFFF, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 12'h000, 0, 0, 0, 0, 1,   0, 12'hFFF, 0, 0, 1, 0));
    // preset bypass on START, then preset rewrite while running
    tbl.push_back(mk(1, 1, 12'h800, 1, 0, 1, 0, 0,   0, 12'h800, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 12'hFFE, 0, 0, 1, 1, 0,   0, 12'h801, 0, 1, 0, 0));

    drive(0, 0, 12'h000, 0, 0, 0, 0, 0);
    tick();
    tick();
    for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

    // 801 -> FFF is 2046 ticks with no TC, then reload uses the rewritten FFE
    drive(1, 0, 12'h000, 0, 0, 1, 1, 0);
    tc_seen = 0;
    for (int i = 0; i < 2046; i++) begin
      tick();
      if (u_if.TC) tc_seen++;
    end
    chk("run801 q", {4'd0, u_if.Q}, 16'h0FFF);
    chk("run801 no tc", tc_seen[15:0], 16'd0);
    tick();
    chk("reload ffe q", {4'd0, u_if.Q}, 16'h0FFE);
    chk("reload ffe tc", {15'd0, u_if.TC}, 16'd1);
    drive(1, 0, 12'h000, 0, 1, 0, 0, 1);
    tick();

    // stage-1 and stage-2 carries at 0FF -> 100
    drive(1, 1, 12'h0FE, 1, 0, 1, 0, 0);
    tick();
    chk("carry q0", {4'd0, u_if.Q}, 16'h00FE);
    drive(1, 0, 12'h000, 0, 0, 1, 1, 0);
    tick();
    chk("carry q1", {4'd0, u_if.Q}, 16'h00FF);
    tick();
    chk("carry q2", {4'd0, u_if.Q}, 16'h0100);
    tick();
    chk("carry q3", {4'd0, u_if.Q}, 16'h0101);
    drive(1, 0, 12'h000, 0, 1, 0, 0, 0);
    tick();

    // one-shot from FF0 with CE every third cycle
    drive(1, 1, 12'hFF0, 1, 0, 0, 0, 0);
    tick();
    exp_q = 12'hFF0;
    done_m = 1'b0;
    nce = 0;
    tc_seen = 0;
    tc_at = 0;
    for (int c = 0; c < 60; c++) begin
      cefl = ((c % 3) == 2);
      drive(1, 0, 12'h000, 0, 0, 0, cefl, 0);
      if (cefl) nce++;
      tick();
      if (cefl && !done_m) begin
        if (exp_q == 12'hFFF) done_m = 1'b1;
        else exp_q = exp_q + 12'd1;
      end
      chk($sformatf("oneshot c%0d q", c), {4'd0, u_if.Q}, {4'd0, exp_q});
      if (u_if.TC) begin
        tc_seen++;
        tc_at = nce;
      end
    end
    chk("oneshot tc count", tc_seen[15:0], 16'd1);
    chk("oneshot tc tick", tc_at[15:0], 16'd16);
    chk("oneshot done", {15'd0, u_if.DONE}, 16'd1);
    chk("oneshot busy", {15'd0, u_if.BUSY}, 16'd0);
    drive(1, 0, 12'h000, 0, 1, 0, 0, 1);
    tick();

    // preset FFF, continuous CE: TC every cycle
    drive(1, 1, 12'hFFF, 1, 0, 1, 1, 0);
    tick();
    chk("fff start q", {4'd0, u_if.Q}, 16'h0FFF);
    chk("fff start tc", {15'd0, u_if.TC}, 16'd0);
    drive(1, 0, 12'h000, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("fff co%0d", i), {15'd0, u_if.CO}, 16'd1);
      tick();
      chk($sformatf("fff tc%0d", i), {15'd0, u_if.TC}, 16'd1);
      chk($sformatf("fff q%0d", i), {4'd0, u_if.Q}, 16'h0FFF);
    end
    drive(1, 0, 12'h000, 0, 1, 0, 0, 1);
    tick();

    // preset 000: TC after exactly 4096 CE ticks
    drive(1, 1, 12'h000, 1, 0, 1, 0, 0);
    tick();
    drive(1, 0, 12'h000, 0, 0, 1, 1, 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!u_if.TC && n < 5000);
    chk("p000 ticks", n[15:0], 16'd4096);
    chk("p000 reload q", {4'd0, u_if.Q}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/c43_timer_ctrl.md
# c43_timer_ctrl

Programmable 12-bit interval timer controller built around a cascade of three 4-bit synchronous up-counter stages with carry look-ahead, matching the load/clear/enable/carry semantics of the Fujitsu counter cells. A small FSM sequences the chain: it presets it, gates counting, detects terminal count, and reloads it or stops. The block sits beside the video/sound timing logic and gives the CPU side a start/stop/preset/interrupt view of one counter chain.

## Interface
Parameters:
- none; width is fixed at 12 bits, three stages of 4.

Ports:
- CK  in  1  system clock; all state changes on rising edge
- nRES  in  1  synchronous reset, active-low, sampled on CK rising edge
- WR_PRE  in  1  preset write strobe; captures PRE into preset register
- PRE  in  12  preset value
- START  in  1  start command pulse
- STOP  in  1  stop command pulse
- MODE  in  1  0 = one-shot, 1 = auto-reload
- CE  in  1  count enable (prescaler tick); one count per CK edge with CE=1
- Q  out  12  current counter value; Q[3:0] stage 0, Q[7:4] stage 1, Q[11:8] stage 2
- CO  out  1  combinational carry out: &Q & CE & (state==RUN)
- TC  out  1  registered terminal-count pulse, one CK wide
- BUSY  out  1  high in RUN
- DONE  out  1  high in DONE state
- IRQ  out  1  sticky interrupt flag
- IRQ_ACK  in  1  clears IRQ

## Operation
- Preset register PREG (12 b): loaded from PRE on any edge with WR_PRE=1, in any state.
- Stage carry: stage k increments only when CE=1 and every lower stage equals 4'hF (stage 0 carry-in = CE). Increment is modulo-16 per stage.
- FSM states IDLE, RUN, DONE.
- IDLE: Q holds. START=1 -> Q <= preset, go RUN. Preset used is PRE if WR_PRE=1 the same cycle (bypass), else PREG.
- RUN: CE=1 and Q!=FFF -> Q <= Q+1. CE=1 and Q==FFF = terminal event: TC <= 1, IRQ <= 1; MODE=1 -> Q <= preset (same bypass rule), stay RUN; MODE=0 -> Q holds FFF, go DONE. CE=0 -> Q holds.
- DONE: Q holds. START -> reload, RUN (as from IDLE). IRQ_ACK does not change state.
- STOP=1 in any state -> go IDLE, Q holds, no TC/IRQ that cycle. STOP beats START and beats a simultaneous terminal event.
- START while in RUN: restart — Q <= preset, stay RUN, no TC even if terminal would occur.
- IRQ: set by terminal event, cleared by IRQ_ACK; set wins if both occur on the same edge.
- MODE sampled at the terminal event edge only; it may change freely while counting.
- Period in auto-reload: TC every 4096 − preset CE ticks; preset FFF -> TC on every CE tick; preset 000 -> every 4096.

## Timing
- Reset (nRES=0 at edge): state IDLE, Q=000, PREG=000, TC=0, IRQ=0; BUSY=0, DONE=0, CO=0. Reset overrides all other inputs, including mid-count.
- START at edge n -> Q=preset, BUSY=1 after edge n; first increment at the first edge > n with CE=1.
- Terminal: CO high combinationally during cycle where Q=FFF, CE=1, RUN; TC, IRQ and reload/DONE all visible after that edge; TC low after the next edge unless another terminal event occurs (possible with preset FFF and continuous CE).
- BUSY/DONE are registered state decodes; no combinational path from inputs except CO.

## Test plan
- Reset: drive nRES=0 with START=1, CE=1 mid-count at Q=123 -> after edge Q=000, IDLE, TC=IRQ=0, BUSY=0.
- Auto-reload: WR_PRE with PRE=FFA, MODE=1, START, CE always 1 -> Q FFA..FFF, TC pulse every 6 CK, Q returns to FFA, IRQ set; IRQ_ACK clears, re-sets on next TC.
- One-shot with gated CE: PRE=FF0, MODE=0, CE every 3rd cycle -> 16 CE ticks to terminal, Q holds FFF, DONE=1, BUSY=0, single TC; stage-1/stage-2 carries ripple correctly at Q=0FF->100 with preset 0FE.
- Collisions: STOP with terminal at Q=FFF -> IDLE, no TC, no IRQ; STOP+START -> IDLE; IRQ_ACK with terminal -> IRQ stays 1.
- Preset bypass/update: WR_PRE PRE=800 with START same cycle -> Q=800; WR_PRE PRE=FFE during RUN -> current count unaffected, next reload uses FFE.
- Preset FFF, MODE=1, CE=1 continuous -> TC held high every cycle, Q stays FFF; preset 000 -> TC after exactly 4096 CE ticks.
